// File: rtl/argon_pkg.sv
// Shared types and constants for the argon instruction sequencer.
// ARGON_SEQ_FLAGS_EN adds the FLG state used for ALU flag capture.
package argon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEL  = 3'd1,
        ST_RDA  = 3'd2,
        ST_RDB  = 3'd3,
        ST_OP   = 3'd4,
        ST_WB   = 3'd5,
`ifdef ARGON_SEQ_FLAGS_EN
        ST_FLG  = 3'd6,
`endif
        ST_DONE = 3'd7
    } state_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] rc;
        logic [3:0] ra;
        logic [3:0] rb;
    } instr_t;

    // Register-select word placed on the bus for the register file
    typedef struct packed {
        logic [3:0] pad;
        logic [3:0] rc;
        logic [3:0] ra;
        logic [3:0] rb;
    } sel_word_t;

    typedef struct packed {
        logic select_latch;
        logic output_a;
        logic output_b;
        logic latch_c;
        logic latch_a;
        logic latch_b;
        logic latch_op;
        logic output_y;
        logic bus_valid;
        logic done;
        logic illegal;
    } ctl_t;

    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_ALU_MAX = 4'hB;

    function automatic sel_word_t sel_word(input instr_t instr);
        sel_word_t w;
        w.pad = 4'h0;
        w.rc  = instr.rc;
        w.ra  = instr.ra;
        w.rb  = instr.rb;
        return w;
    endfunction

endpackage

// File: rtl/argon_seq_decode.sv
// Combinational opcode classifier for the argon sequencer.
module argon_seq_decode
    import argon_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_nop,
    output logic       is_alu,
    output logic       is_illegal
);

    // Split the opcode space into NOP, ALU and illegal ranges
    always_comb begin
        is_nop     = (opcode == OP_NOP);
        is_alu     = (opcode != OP_NOP) && (opcode <= OP_ALU_MAX);
        is_illegal = (opcode > OP_ALU_MAX);
    end

endmodule

// File: rtl/argon_sequencer.sv
// Multi-cycle sequencer driving register-file and ALU strobes over a shared bus.
// Optional flag capture (FLG state, o_flags) is enabled by ARGON_SEQ_FLAGS_EN.
module argon_sequencer
    import argon_pkg::*;
(
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic [15:0] i_instr,
    input  logic        i_instr_valid,
    output logic        o_instr_ready,
    input  logic        i_hold,
    input  logic [15:0] i_bus,
    output logic [15:0] o_bus,
    output logic        o_bus_valid,
    output logic        o_selectLatch,
    output logic        o_outputA,
    output logic        o_outputB,
    output logic        o_latchC,
    output logic        o_latchA,
    output logic        o_latchB,
    output logic        o_latchOp,
    output logic        o_latchF,
    output logic        o_outputY,
    output logic        o_outputF,
    output logic        o_done,
    output logic        o_illegal,
    output logic        o_busy
`ifdef ARGON_SEQ_FLAGS_EN
    ,
    output logic [3:0]  o_flags
`endif
);

    state_t      state_r;
    instr_t      instr_r;
    instr_t      instr_s;
    ctl_t        ctl_r;
    ctl_t        ctl_s;
    logic [15:0] bus_r;
    logic        busy_r;
    logic        is_nop_s;
    logic        is_alu_s;
    logic        is_illegal_s;
    logic        unused_s;
`ifdef ARGON_SEQ_FLAGS_EN
    logic [3:0]  flags_r;
    logic        latch_f_r;
    logic        output_f_r;
`endif

    assign instr_s = i_instr;

    argon_seq_decode u_decode (
        .opcode     (instr_s.opcode),
        .is_nop     (is_nop_s),
        .is_alu     (is_alu_s),
        .is_illegal (is_illegal_s)
    );

    // Sequencer FSM; outputs are registered from the state being entered
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_r <= ST_IDLE;
            instr_r <= '0;
            ctl_r   <= '0;
            bus_r   <= 16'h0000;
            busy_r  <= 1'b0;
`ifdef ARGON_SEQ_FLAGS_EN
            flags_r    <= 4'h0;
            latch_f_r  <= 1'b0;
            output_f_r <= 1'b0;
`endif
        end else if (i_hold) begin
            state_r <= state_r;
        end else begin
            ctl_r  <= '0;
            bus_r  <= 16'h0000;
            busy_r <= 1'b1;
`ifdef ARGON_SEQ_FLAGS_EN
            latch_f_r  <= 1'b0;
            output_f_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (i_instr_valid) begin
                        instr_r <= instr_s;
                        if (is_alu_s) begin
                            state_r            <= ST_SEL;
                            bus_r              <= sel_word(instr_s);
                            ctl_r.bus_valid    <= 1'b1;
                            ctl_r.select_latch <= 1'b1;
                        end else begin
                            state_r       <= ST_DONE;
                            ctl_r.done    <= 1'b1;
                            ctl_r.illegal <= is_illegal_s;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_SEL: begin
                    state_r        <= ST_RDA;
                    ctl_r.output_a <= 1'b1;
                    ctl_r.latch_a  <= 1'b1;
                end
                ST_RDA: begin
                    state_r        <= ST_RDB;
                    ctl_r.output_b <= 1'b1;
                    ctl_r.latch_b  <= 1'b1;
                end
                ST_RDB: begin
                    state_r         <= ST_OP;
                    bus_r           <= {12'h000, instr_r.opcode};
                    ctl_r.bus_valid <= 1'b1;
                    ctl_r.latch_op  <= 1'b1;
                end
                ST_OP: begin
                    state_r        <= ST_WB;
                    ctl_r.output_y <= 1'b1;
                    ctl_r.latch_c  <= 1'b1;
                end
                ST_WB: begin
`ifdef ARGON_SEQ_FLAGS_EN
                    state_r    <= ST_FLG;
                    latch_f_r  <= 1'b1;
                    output_f_r <= 1'b1;
`else
                    state_r    <= ST_DONE;
                    ctl_r.done <= 1'b1;
`endif
                end
`ifdef ARGON_SEQ_FLAGS_EN
                ST_FLG: begin
                    // The ALU is driving its flags onto the bus during this state
                    flags_r    <= i_bus[3:0];
                    state_r    <= ST_DONE;
                    ctl_r.done <= 1'b1;
                end
`endif
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Hold masks every strobe and handshake without disturbing the sequence
    assign ctl_s         = i_hold ? '0 : ctl_r;
    assign o_bus         = i_hold ? 16'h0000 : bus_r;
    assign o_instr_ready = (state_r == ST_IDLE) && !i_hold;
    assign o_bus_valid   = ctl_s.bus_valid;
    assign o_selectLatch = ctl_s.select_latch;
    assign o_outputA     = ctl_s.output_a;
    assign o_outputB     = ctl_s.output_b;
    assign o_latchC      = ctl_s.latch_c;
    assign o_latchA      = ctl_s.latch_a;
    assign o_latchB      = ctl_s.latch_b;
    assign o_latchOp     = ctl_s.latch_op;
    assign o_outputY     = ctl_s.output_y;
    assign o_done        = ctl_s.done;
    assign o_illegal     = ctl_s.illegal;
    assign o_busy        = busy_r;
`ifdef ARGON_SEQ_FLAGS_EN
    assign o_latchF      = latch_f_r && !i_hold;
    assign o_outputF     = output_f_r && !i_hold;
    assign o_flags       = flags_r;
`else
    assign o_latchF      = 1'b0;
    assign o_outputF     = 1'b0;
`endif

    assign unused_s = ^{i_bus, instr_r.rc, instr_r.ra, instr_r.rb, is_nop_s};

endmodule

// File: tb/tb_argon_sequencer.sv
// Self-checking bench for argon_sequencer: directed scenarios plus random traffic
// compared against a per-instruction expected-phase queue.
module tb_argon_sequencer;

    logic        i_Clk = 1'b0;
    logic        i_Reset;
    logic [15:0] i_instr;
    logic        i_instr_valid;
    logic        o_instr_ready;
    logic        i_hold;
    logic [15:0] i_bus;
    logic [15:0] o_bus;
    logic        o_bus_valid;
    logic        o_selectLatch, o_outputA, o_outputB, o_latchC;
    logic        o_latchA, o_latchB, o_latchOp, o_latchF, o_outputY, o_outputF;
    logic        o_done, o_illegal, o_busy;
`ifdef ARGON_SEQ_FLAGS_EN
    logic [3:0]  o_flags;
`endif

    argon_sequencer dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset),
        .i_instr(i_instr), .i_instr_valid(i_instr_valid), .o_instr_ready(o_instr_ready),
        .i_hold(i_hold), .i_bus(i_bus), .o_bus(o_bus), .o_bus_valid(o_bus_valid),
        .o_selectLatch(o_selectLatch), .o_outputA(o_outputA), .o_outputB(o_outputB),
        .o_latchC(o_latchC), .o_latchA(o_latchA), .o_latchB(o_latchB),
        .o_latchOp(o_latchOp), .o_latchF(o_latchF), .o_outputY(o_outputY),
        .o_outputF(o_outputF), .o_done(o_done), .o_illegal(o_illegal), .o_busy(o_busy)
`ifdef ARGON_SEQ_FLAGS_EN
        , .o_flags(o_flags)
`endif
    );

    always #5 i_Clk = ~i_Clk;

    // One expected output phase; strb = {sel,oA,oB,lC,lA,lB,lOp,lF,oY,oF}
    typedef struct {
        logic [15:0] bus;
        logic [9:0]  strb;
        logic        valid;
        logic        done;
        logic        illegal;
        logic        flg;
    } ent_t;

    ent_t        q[$];
    logic [3:0]  flags_m = 4'h0;
    logic [15:0] bus_drv = 16'h0000;
    int          checks = 0;
    int          errors = 0;
    bit          init_done = 1'b0;
    int          lat;
    int          done_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk(input logic [15:0] bus, input logic [9:0] strb, input logic valid,
                                input logic done, input logic illegal, input logic flg);
        ent_t e;
        e.bus = bus; e.strb = strb; e.valid = valid; e.done = done; e.illegal = illegal; e.flg = flg;
        return e;
    endfunction

    // Phases an instruction walks through, built from the opcode classes
    task automatic push_instr(input logic [15:0] ins);
        logic [3:0] op;
        op = ins[15:12];
        if (op == 4'h0 || op > 4'hB) begin
            q.push_back(mk(16'h0000, 10'b0000000000, 1'b0, 1'b1, op > 4'hB, 1'b0));
        end else begin
            q.push_back(mk({4'h0, ins[11:0]}, 10'b1000000000, 1'b1, 1'b0, 1'b0, 1'b0));
            q.push_back(mk(16'h0000,          10'b0100100000, 1'b0, 1'b0, 1'b0, 1'b0));
            q.push_back(mk(16'h0000,          10'b0010010000, 1'b0, 1'b0, 1'b0, 1'b0));
            q.push_back(mk({12'h000, op},     10'b0000001000, 1'b1, 1'b0, 1'b0, 1'b0));
            q.push_back(mk(16'h0000,          10'b0001000010, 1'b0, 1'b0, 1'b0, 1'b0));
`ifdef ARGON_SEQ_FLAGS_EN
            q.push_back(mk(16'h0000,          10'b0000000101, 1'b0, 1'b0, 1'b0, 1'b1));
`endif
            q.push_back(mk(16'h0000, 10'b0000000000, 1'b0, 1'b1, 1'b0, 1'b0));
        end
    endtask

    function automatic logic [30:0] exp_vec();
        if (q.size() == 0)
            return {~i_hold, 16'h0000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
        else if (i_hold)
            return {1'b0, 16'h0000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1};
        else
            return {1'b0, q[0].bus, q[0].valid, q[0].strb, q[0].done, q[0].illegal, 1'b1};
    endfunction

    function automatic logic [30:0] act_vec();
        return {o_instr_ready, o_bus, o_bus_valid, o_selectLatch, o_outputA, o_outputB,
                o_latchC, o_latchA, o_latchB, o_latchOp, o_latchF, o_outputY, o_outputF,
                o_done, o_illegal, o_busy};
    endfunction

    // One clock: drive on the falling edge, advance the model on the rising edge
    task automatic cyc(input logic rst, input logic hold, input logic valid, input logic [15:0] ins);
        @(negedge i_Clk);
        i_Reset = rst; i_hold = hold; i_instr_valid = valid; i_instr = ins; i_bus = bus_drv;
        if (init_done) begin
            #1;
            check("mid_outputs", {1'b0, act_vec()}, {1'b0, exp_vec()});
        end
        @(posedge i_Clk);
        if (rst) begin
            q.delete();
            flags_m = 4'h0;
        end else if (!hold) begin
            if (q.size() == 0) begin
                if (valid) push_instr(ins);
            end else begin
                if (q[0].flg) flags_m = bus_drv[3:0];
                void'(q.pop_front());
            end
        end
        #1;
        check("outputs", {1'b0, act_vec()}, {1'b0, exp_vec()});
`ifdef ARGON_SEQ_FLAGS_EN
        check("flags", {28'h0, o_flags}, {28'h0, flags_m});
`endif
    endtask

    task automatic measure(input int start, output int n);
        n = start;
        while (o_done !== 1'b1 && n < 30) begin
            cyc(1'b0, 1'b0, 1'b0, 16'h0000);
            n++;
        end
    endtask

    initial begin
        int alu_lat;
`ifdef ARGON_SEQ_FLAGS_EN
        alu_lat = 7;
`else
        alu_lat = 6;
`endif
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        init_done = 1'b1;
        cyc(1'b1, 1'b0, 1'b1, 16'h3215);
        check("reset_ready", {31'h0, o_instr_ready}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);

        // ALU op 0x3215
        cyc(1'b0, 1'b0, 1'b1, 16'h3215);
        check("sel_bus", {16'h0, o_bus}, 32'h0000_0215);
        measure(1, lat);
        check("alu_latency", lat, alu_lat);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);

        // NOP
        cyc(1'b0, 1'b0, 1'b1, 16'h0000);
        measure(1, lat);
        check("nop_latency", lat, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);

        // Illegal opcode
        cyc(1'b0, 1'b0, 1'b1, 16'hE123);
        check("illegal_pulse", {30'h0, o_illegal, o_done}, 32'd3);
        measure(1, lat);
        check("illegal_latency", lat, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);

        // Hold for three cycles while in RDB
        cyc(1'b0, 1'b0, 1'b1, 16'h3215);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        check("rdb_before_hold", {31'h0, o_outputB}, 32'd1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 16'h0000);
        measure(6, lat);
        check("hold_latency", lat, alu_lat + 3);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);

        // Reset while in OP aborts the sequence
        cyc(1'b0, 1'b0, 1'b1, 16'h3215);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        check("in_op", {31'h0, o_latchOp}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("abort_ready", {31'h0, o_instr_ready}, 32'd1);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 16'h0000);
            if (o_done === 1'b1) done_cnt++;
        end
        check("abort_no_done", done_cnt, 32'd0);

        // Valid held high through a busy sequence, then back-to-back
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, (i == 0) ? 16'h1111 : 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);

`ifdef ARGON_SEQ_FLAGS_EN
        bus_drv = 16'h000A;
        cyc(1'b0, 1'b0, 1'b1, 16'h5678);
        measure(1, lat);
        check("flag_latency", lat, 32'd7);
        check("flag_value", {28'h0, o_flags}, 32'h0000_000A);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
`endif

        // Random traffic including hold, reset-with-hold and valid-while-busy
        for (int i = 0; i < 600; i++) begin
            bus_drv = 16'($urandom);
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 6) == 0,
                1'($urandom_range(0, 1)), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/argon_sequencer.md
ARGON_SEQUENCER -- requirements
Module: argon_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: i_Clk  in  1  rising-edge clock; i_Reset  in  1  synchronous active-high reset.
REQ-002 The block SHALL have these instruction handshake ports: i_instr  in  16  instruction word; i_instr_valid  in  1  instruction offered; o_instr_ready  out  1  high only in IDLE when i_hold is low.
REQ-003 The block SHALL have i_hold  in  1, which freezes the FSM while high.
REQ-004 The block SHALL have these bus ports: i_bus  in  16  shared bus; o_bus  out  16  sequencer bus data; o_bus_valid  out  1  sequencer drives bus.
REQ-005 The block SHALL have these register-file strobes, each out 1: o_selectLatch, o_outputA, o_outputB, o_latchC.
REQ-006 The block SHALL have these ALU strobes, each out 1: o_latchA, o_latchB, o_latchOp, o_latchF, o_outputY, o_outputF.
REQ-007 The block SHALL have these status ports: o_done  out  1  one-cycle completion pulse; o_illegal  out  1  one-cycle pulse on illegal opcode; o_busy  out  1  high in any state other than IDLE.

Function
REQ-008 Instruction fields SHALL be: [15:12] opcode, [11:8] rc (destination), [7:4] ra, [3:0] rb.
REQ-009 Opcode 0x0 SHALL be NOP, opcodes 0x1-0xB SHALL be ALU ops, and opcodes 0xC-0xF SHALL be illegal.
REQ-010 An instruction SHALL be accepted on a cycle with i_instr_valid & o_instr_ready, and it SHALL be registered into an internal instruction register.
REQ-011 FSM states SHALL be IDLE, SEL, RDA, RDB, OP, WB, FLG (FLG only with the macro), and DONE.
REQ-012 Transitions SHALL be:
- IDLE -> SEL for an ALU op.
- IDLE -> DONE for NOP or illegal.
- SEL -> RDA -> RDB -> OP -> WB.
- WB -> DONE, or WB -> FLG -> DONE.
- DONE -> IDLE.
REQ-013 SEL SHALL assert: o_bus = {4'h0, rc, ra, rb}; o_bus_valid; o_selectLatch.
REQ-014 RDA SHALL assert o_outputA and o_latchB... correction: RDA SHALL assert o_outputA and o_latchA.
REQ-015 RDB SHALL assert o_outputB and o_latchB.
REQ-016 OP SHALL assert: o_bus = {12'h000, opcode}; o_bus_valid; o_latchOp.
REQ-017 WB SHALL assert o_outputY and o_latchC.
REQ-018 DONE SHALL pulse o_done for exactly one cycle, plus o_illegal if the opcode was illegal.
REQ-019 Outside the states listed in REQ-013 to REQ-018, every strobe SHALL be 0 and o_bus SHALL be 16'h0000.
REQ-020 At most one bus source (sequencer, register file, or ALU) SHALL be enabled in any cycle.
REQ-021 While i_hold is high:
- the state SHALL be unchanged;
- all strobes, o_bus_valid, o_done, o_illegal and o_instr_ready SHALL be 0;
- the sequence SHALL resume in the same state when i_hold falls.
REQ-022 ALU-op latency from the accept cycle to o_done SHALL be 6 cycles, or 7 with FLG.
REQ-023 NOP/illegal latency from the accept cycle to o_done SHALL be 1 cycle.
REQ-024 A valid instruction offered during busy SHALL be ignored and not queued.
REQ-025 A back-to-back instruction SHALL be accepted on the cycle after DONE.

Reset
REQ-026 i_Reset SHALL force state IDLE, clear the instruction register and o_flags to 0, and set all outputs to 0 except o_instr_ready.
REQ-027 Reset asserted mid-sequence SHALL abort the sequence with no o_done, and it SHALL take priority over i_hold.

Configuration
REQ-028 The macro ARGON_SEQ_FLAGS_EN SHALL control flag capture.
REQ-029 When ARGON_SEQ_FLAGS_EN is defined:
- the block SHALL add output o_flags  out  4;
- state FLG SHALL assert o_outputF and o_latchF;
- o_flags SHALL load i_bus[3:0] at the end of FLG.
REQ-030 When ARGON_SEQ_FLAGS_EN is undefined: FLG and o_flags SHALL be absent, WB SHALL go to DONE, and o_outputF and o_latchF SHALL be tied to 0.

Structure
REQ-031 The state enum, the instruction field struct, the opcode constants (OP_NOP, OP_ALU_MAX=4'hB) and the reg-select word struct SHALL live in argon_pkg.
REQ-032 Decode SHALL be the sub-module argon_seq_decode (combinational: opcode -> is_nop / is_alu / is_illegal), instantiated once.

Verification
REQ-033 Accept i_instr=16'h3215 -> SEL with o_bus=16'h0215; then RDA, RDB, then OP with o_bus=16'h0003; then WB; o_done exactly 6 cycles after accept.
REQ-034 i_instr=16'h0000 (NOP) -> o_done 1 cycle after accept; no strobes asserted.
REQ-035 i_instr=16'hE123 -> o_illegal and o_done together 1 cycle after accept; no strobes asserted.
REQ-036 i_hold high for 3 cycles while in RDB -> all strobes 0 during hold; RDB repeats after release; o_done delayed by 3 cycles.
REQ-037 i_Reset for 1 cycle while in OP -> IDLE next cycle; o_done never asserted; o_instr_ready=1.
REQ-038 With ARGON_SEQ_FLAGS_EN and i_bus=16'h000A during FLG -> o_flags=4'hA; o_done 7 cycles after accept.
